// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline sequencing logic.
//   REG_ADDR_W  : width of a register-file address
//   hzd_state_e : hazard controller sequencing states
package arm_pkg;

   localparam int REG_ADDR_W = 4;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } hzd_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Purely combinational RAW compare of the ID-stage sources against the
// destinations currently in EXE and MEM.
//   in  id_valid, src1, src2, two_src    : ID-stage operand information
//   in  exe_dest, exe_wb_en              : EXE-stage writer
//   in  mem_dest, mem_wb_en              : MEM-stage writer
//   out raw_exe, raw_mem                 : read-after-write dependence flags
module hazard_detect
   import arm_pkg::*;
(
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] src1,
   input  logic [REG_ADDR_W-1:0] src2,
   input  logic                  two_src,
   input  logic [REG_ADDR_W-1:0] exe_dest,
   input  logic                  exe_wb_en,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   input  logic                  mem_wb_en,
   output logic                  raw_exe,
   output logic                  raw_mem
);

   assign raw_exe = id_valid && exe_wb_en &&
                    ((src1 == exe_dest) || (two_src && (src2 == exe_dest)));
   assign raw_mem = id_valid && mem_wb_en &&
                    ((src1 == mem_dest) || (two_src && (src2 == mem_dest)));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage ARM core: decides IF/ID
// freezes, EXE bubbles and whole-pipe freezes for a slow data memory, detects
// memory handshake timeouts and counts stall cycles.
//
// Build option: FORWARDING_EN -- when defined, only load-use against EXE
// stalls and fwd_en=1; when undefined, any RAW against EXE or MEM stalls.
//
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   id_valid, src1, src2, two_src    : ID-stage operands
//   exe_dest, exe_wb_en, exe_mem_r_en: EXE-stage writer / load flag
//   mem_dest, mem_wb_en              : MEM-stage writer
//   mem_req, mem_ready               : data memory handshake
//   fault_clr                        : leave FAULT
//   freeze_if/id/exe/mem, bubble_exe : pipeline control (combinational)
//   fwd_en                           : forwarding mux enable (constant)
//   mem_fault                        : memory timeout, held until fault_clr
//   stall_cycles                     : saturating count of freeze_if cycles
//
// state    | meaning
// RUN      | normal flow; data stalls handled with a one-cycle bubble
// MEM_WAIT | whole pipe frozen waiting for mem_ready
// FAULT    | memory timed out; pipe frozen until fault_clr
module hazard_controller
   import arm_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] src1,
   input  logic [REG_ADDR_W-1:0] src2,
   input  logic                  two_src,
   input  logic [REG_ADDR_W-1:0] exe_dest,
   input  logic                  exe_wb_en,
   input  logic                  exe_mem_r_en,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   input  logic                  mem_wb_en,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   input  logic                  fault_clr,
   output logic                  freeze_if,
   output logic                  freeze_id,
   output logic                  freeze_exe,
   output logic                  freeze_mem,
   output logic                  bubble_exe,
   output logic                  fwd_en,
   output logic                  mem_fault,
   output logic [CNT_W-1:0]      stall_cycles
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   // wait_cnt holds the number of stalled cycles already completed, so the
   // current cycle is stall number wait_cnt+1; the timeout fires when that
   // reaches MEM_TIMEOUT.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   hzd_state_e        state, state_next;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
   logic              raw_exe, raw_mem;
   logic              data_stall, mem_stall;

   hazard_detect u_detect (
      .id_valid  (id_valid),
      .src1      (src1),
      .src2      (src2),
      .two_src   (two_src),
      .exe_dest  (exe_dest),
      .exe_wb_en (exe_wb_en),
      .mem_dest  (mem_dest),
      .mem_wb_en (mem_wb_en),
      .raw_exe   (raw_exe),
      .raw_mem   (raw_mem)
   );

`ifdef FORWARDING_EN
   assign fwd_en     = 1'b1;
   assign data_stall = raw_exe && exe_mem_r_en;
`else
   assign fwd_en     = 1'b0;
   assign data_stall = raw_exe || raw_mem;
`endif

   assign mem_stall = mem_req && !mem_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      freeze_if     = 1'b0;
      freeze_id     = 1'b0;
      freeze_exe    = 1'b0;
      freeze_mem    = 1'b0;
      bubble_exe    = 1'b0;
      mem_fault     = 1'b0;
      case (state)
         RUN: begin
            if (mem_stall) begin
               {freeze_if, freeze_id, freeze_exe, freeze_mem} = 4'b1111;
               wait_cnt_next = WAIT_W'(1);
               state_next    = MEM_WAIT;
            end else if (data_stall) begin
               freeze_if  = 1'b1;
               freeze_id  = 1'b1;
               bubble_exe = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               // Memory completes: pipe moves this cycle, so normal data
               // hazard handling applies.
               state_next    = RUN;
               wait_cnt_next = '0;
               if (data_stall) begin
                  freeze_if  = 1'b1;
                  freeze_id  = 1'b1;
                  bubble_exe = 1'b1;
               end
            end else begin
               {freeze_if, freeze_id, freeze_exe, freeze_mem} = 4'b1111;
               if (wait_cnt == WAIT_LAST) state_next = FAULT;
               else wait_cnt_next = wait_cnt + WAIT_W'(1);
            end
         end
         FAULT: begin
            {freeze_if, freeze_id, freeze_exe, freeze_mem} = 4'b1111;
            mem_fault = 1'b1;
            if (fault_clr) begin
               state_next    = RUN;
               wait_cnt_next = '0;
            end
         end
         default: state_next = RUN;
      endcase
      // Outputs must fall the instant reset is asserted, even if stall
      // inputs are still active.
      if (!rst_n) begin
         freeze_if  = 1'b0;
         freeze_id  = 1'b0;
         freeze_exe = 1'b0;
         freeze_mem = 1'b0;
         bubble_exe = 1'b0;
         mem_fault  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (freeze_if && (stall_cycles != {CNT_W{1'b1}}))
         stall_cycles <= stall_cycles + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller (MEM_TIMEOUT=4, CNT_W=8).
module tb_hazard_controller;
   import arm_pkg::*;

`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic id_valid, two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
   logic mem_req, mem_ready, fault_clr;
   logic [3:0] src1, src2, exe_dest, mem_dest;
   logic freeze_if, freeze_id, freeze_exe, freeze_mem, bubble_exe, fwd_en, mem_fault;
   logic [CW-1:0] stall_cycles;

   hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .src1(src1), .src2(src2),
      .two_src(two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .mem_req(mem_req), .mem_ready(mem_ready), .fault_clr(fault_clr),
      .freeze_if(freeze_if), .freeze_id(freeze_id), .freeze_exe(freeze_exe),
      .freeze_mem(freeze_mem), .bubble_exe(bubble_exe), .fwd_en(fwd_en),
      .mem_fault(mem_fault), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]    fz;
      logic          bub;
      logic          flt;
      logic [CW-1:0] sc;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;
   logic [CW-1:0] exp_sc = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         chk({nm, " ctl"},
             {26'd0, freeze_if, freeze_id, freeze_exe, freeze_mem, bubble_exe, mem_fault},
             {26'd0, e.fz, e.bub, e.flt});
         chk({nm, " cnt"}, {24'd0, stall_cycles}, {24'd0, e.sc});
      end
   end

   task automatic idle_inputs();
      id_valid = 0; src1 = 0; src2 = 0; two_src = 0; exe_dest = 0; exe_wb_en = 0;
      exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0; mem_req = 0; mem_ready = 0;
      fault_clr = 0;
   endtask

   // Drive one cycle of inputs and push the hand-computed response.
   task automatic step(input logic iv, input logic [3:0] s1, input logic [3:0] s2,
                       input logic ts, input logic [3:0] ed, input logic ewb,
                       input logic eld, input logic [3:0] md, input logic mwb,
                       input logic mrq, input logic mrdy, input logic fclr,
                       input logic [3:0] fz, input logic bub, input logic flt,
                       input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      id_valid = iv; src1 = s1; src2 = s2; two_src = ts; exe_dest = ed;
      exe_wb_en = ewb; exe_mem_r_en = eld; mem_dest = md; mem_wb_en = mwb;
      mem_req = mrq; mem_ready = mrdy; fault_clr = fclr;
      e.fz = fz; e.bub = bub; e.flt = flt; e.sc = exp_sc;
      exp_q.push_back(e);
      name_q.push_back(nm);
      if (fz[3] && exp_sc != {CW{1'b1}}) exp_sc = exp_sc + 1'b1;
   endtask

   task automatic idle(input string nm);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, nm);
   endtask

   initial begin
      logic [3:0] nf;
      nf = FWD ? 4'b0000 : 4'b1100;
      idle_inputs();
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
      chk("fwd_en", {31'd0, fwd_en}, {31'd0, FWD});

      idle("reset");
      //   iv s1 s2 ts ed ewb eld md mwb rq rdy clr  fz       bub flt
      step(1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 4'b1100, 1, 0, "load_use");
      step(1, 3, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, nf, !FWD, 0, "load_in_mem");
      idle("after_load_use");
      step(1, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, nf, !FWD, 0, "alu_raw_exe");
      step(1, 3, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, nf, !FWD, 0, "alu_raw_mem");
      step(1, 1, 5, 0, 5, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, "src2_unused");
      step(1, 1, 5, 1, 5, 1, 1, 0, 0, 0, 0, 0, 4'b1100, 1, 0, "src2_load_use");
      step(0, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, "id_invalid");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 0, 0, "req_ready_same");
      // memory stall wins over a simultaneous load-use hazard
      step(1, 3, 0, 0, 3, 1, 1, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "mem_stall_1");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "mem_stall_2");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "mem_stall_3");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 0, 0, "mem_release");
      idle("run_after_mem");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "mem_stall_b");
      step(1, 3, 0, 0, 3, 1, 1, 0, 0, 1, 1, 0, 4'b1100, 1, 0, "release_load_use");
      idle("run_b");
      // timeout: four stalled cycles, FAULT from the fifth
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "to_1");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "to_2");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "to_3");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "to_4");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b1111, 0, 1, "fault_ready_ign");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b1111, 0, 1, "fault_hold");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 0, 1, "fault_clr");
      idle("run_after_clr");
      // wait_cnt must restart from zero: timeout again after exactly four
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "to2_1");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "to2_2");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "to2_3");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "to2_4");
      for (int i = 0; i < 280; i++)
         step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 1, "fault_long");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 0, 1, "fault_clr2");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "pre_rst_1");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "pre_rst_2");
      // asynchronous reset in MEM_WAIT with the stall inputs still active
      @(posedge clk);
      #6;
      rst_n = 1'b0;
      #1;
      chk("rst_freeze", {28'd0, freeze_if, freeze_id, freeze_exe, freeze_mem}, 32'd0);
      chk("rst_fault_bub", {30'd0, mem_fault, bubble_exe}, 32'd0);
      chk("rst_cnt", {24'd0, stall_cycles}, 32'd0);
      exp_sc = '0;
      idle_inputs();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle("after_rst");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, "after_rst_ready");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0, "post_rst_stall");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 0, 0, "post_rst_rel");
      idle("final");

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
